ysyx_24100005_mem_arbiter: RTL and testbench
============================================

YSYX_24100005_MEM_ARBITER -- requirements
Module: ysyx_24100005_mem_arbiter

Interface
REQ-001 Parameter MAX_LSU_STREAK, default 4, is the number of consecutive LSU grants allowed while IFU waits; legal range 1..7.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ifu_req_valid  in  1  IFU fetch request pending.
REQ-006 ifu_req_ready  out  1  IFU request accepted this cycle.
REQ-007 ifu_raddr  in  32  IFU fetch address (PC).
REQ-008 ifu_resp_valid  out  1  IFU read data valid, one-cycle pulse.
REQ-009 ifu_rdata  out  32  IFU read data.
REQ-010 lsu_req_valid  in  1  LSU load/store request pending.
REQ-011 lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-012 lsu_addr  in  32  LSU byte address.
REQ-013 lsu_wen  in  1  1 = store, 0 = load.
REQ-014 lsu_wdata  in  32  store data.
REQ-015 lsu_wmask  in  8  store byte mask.
REQ-016 lsu_resp_valid  out  1  LSU load data or store ack valid, one-cycle pulse.
REQ-017 lsu_rdata  out  32  LSU load data.
REQ-018 mem_req_valid  out  1  request to shared memory port.
REQ-019 mem_req_ready  in  1  memory accepts request.
REQ-020 mem_addr / mem_wen / mem_wdata / mem_wmask  out  32/1/32/8  latched request fields.
REQ-021 mem_resp_valid  in  1  memory response (read data or write ack).
REQ-022 mem_rdata  in  32  memory read data.

Function
REQ-023 FSM states: IDLE, REQ, WAIT; owner register: IFU or LSU; one transaction outstanding at most.
REQ-024 IDLE: when any req_valid is high, exactly one *_req_ready is driven high combinationally for the winner, its fields are latched, owner is set, next state is REQ.
REQ-025 Priority: LSU wins over IFU, except when streak == MAX_LSU_STREAK and ifu_req_valid is high, in which case IFU wins.
REQ-026 Streak counter (3 bit): increments on an LSU grant while ifu_req_valid is high; it clears on an IFU grant or on any IDLE cycle in which ifu_req_valid is low; it saturates at MAX_LSU_STREAK.
REQ-027 REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready=1 the next state is WAIT; otherwise the FSM stays in REQ (no timeout).
REQ-028 For an IFU owner: mem_wen=0 and mem_wmask=8'h00; mem_wdata=0.
REQ-029 WAIT: on mem_resp_valid=1 the owner's resp_valid=1 in the same cycle, *_rdata=mem_rdata, and the next state is IDLE; the other requester's resp_valid stays 0.
REQ-030 Stores also complete through WAIT on mem_resp_valid (ack); lsu_rdata is don't-care for stores.
REQ-031 mem_resp_valid in IDLE or REQ is ignored: no resp pulse and no state change.
REQ-032 *_req_ready=0 in REQ and WAIT; new requests wait in IDLE, so minimum back-to-back spacing is 3 cycles (IDLE, REQ, WAIT).
REQ-033 A requester dropping req_valid after acceptance has no effect; its transaction completes.
REQ-034 *_rdata outputs are 0 whenever the corresponding resp_valid is 0.

Reset
REQ-035 rst=1 at a rising edge: state=IDLE, owner=IFU, streak=0, latched fields=0; this applies mid-transaction, and any in-flight transaction is dropped with no resp pulse.
REQ-036 While rst=1: all *_req_ready, *_resp_valid and mem_req_valid are 0.

Verification
REQ-037 IFU only, ifu_raddr=32'h8000_0000, mem_req_ready=1, mem_resp_valid one cycle later with rdata=32'h0010_0093 -> mem_addr=32'h8000_0000 in REQ; ifu_resp_valid pulse with ifu_rdata=32'h0010_0093; total 3 cycles.
REQ-038 Both valid in IDLE, streak=0 -> lsu_req_ready=1 and ifu_req_ready=0; IFU is served in the following transaction.
REQ-039 LSU and IFU both held valid continuously, MAX_LSU_STREAK=4 -> grant sequence is LSU,LSU,LSU,LSU,IFU,LSU...
REQ-040 LSU store addr=32'h8000_1002, wdata=32'hABCD_0000, wmask=8'h0C, mem_req_ready low 3 cycles -> fields held stable for 4 cycles of REQ; lsu_resp_valid pulses on the ack.
REQ-041 rst asserted in WAIT, then mem_resp_valid asserted -> no resp pulse; FSM is in IDLE; the next request is served normally.
REQ-042 mem_resp_valid pulsed in IDLE -> no resp_valid on either side; state stays IDLE.

Source files
------------

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Two-master arbiter (IFU fetch, LSU load/store) onto one shared memory port.
// One transaction in flight; LSU has priority, bounded by an anti-starvation streak.
module ysyx_24100005_mem_arbiter #(
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_raddr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [2:0] MAX_S = 3'(MAX_LSU_STREAK);

  state_t      state_q, state_d;
  logic        owner_lsu_q;
  logic [2:0]  streak_q;
  logic [31:0] addr_q, wdata_q;
  logic        wen_q;
  logic [7:0]  wmask_q;
  logic        lsu_win, ifu_win;

  // IFU takes the slot once LSU has used up its streak while IFU was waiting
  assign lsu_win = lsu_req_valid && !(ifu_req_valid && streak_q == MAX_S);
  assign ifu_win = ifu_req_valid && !lsu_win;

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  always_comb begin
    state_d        = state_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = 32'h0;
    lsu_rdata      = 32'h0;
    case (state_q)
      IDLE: begin
        lsu_req_ready = lsu_win;
        ifu_req_ready = ifu_win;
        if (lsu_win || ifu_win) state_d = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          if (owner_lsu_q) begin
            lsu_resp_valid = 1'b1;
            lsu_rdata      = mem_rdata;
          end else begin
            ifu_resp_valid = 1'b1;
            ifu_rdata      = mem_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // reset silences every handshake, including a response landing this cycle
    if (rst) begin
      state_d        = IDLE;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      mem_req_valid  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      ifu_rdata      = 32'h0;
      lsu_rdata      = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_lsu_q <= 1'b0;
      streak_q    <= 3'd0;
      addr_q      <= 32'h0;
      wen_q       <= 1'b0;
      wdata_q     <= 32'h0;
      wmask_q     <= 8'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (lsu_win) begin
          owner_lsu_q <= 1'b1;
          addr_q      <= lsu_addr;
          wen_q       <= lsu_wen;
          wdata_q     <= lsu_wdata;
          wmask_q     <= lsu_wmask;
          if (!ifu_req_valid)        streak_q <= 3'd0;
          else if (streak_q != MAX_S) streak_q <= streak_q + 3'd1;
        end else if (ifu_win) begin
          owner_lsu_q <= 1'b0;
          addr_q      <= ifu_raddr;
          wen_q       <= 1'b0;
          wdata_q     <= 32'h0;
          wmask_q     <= 8'h0;
          streak_q    <= 3'd0;
        end else begin
          streak_q <= 3'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter; inputs change and outputs are
// checked 1ns after each rising edge, then 1ns later again after input settle.
module tb_ysyx_24100005_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_raddr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int errors = 0;
  int checks = 0;

  ysyx_24100005_mem_arbiter #(.MAX_LSU_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_raddr(ifu_raddr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_raddr = 32'h0;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 8'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    tick; tick;

    // reset: handshakes gated even with requests asserted
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_resp_valid = 1'b1;
    #1;
    chk1("rst_ifu_ready", ifu_req_ready, 1'b0);
    chk1("rst_lsu_ready", lsu_req_ready, 1'b0);
    chk1("rst_mem_valid", mem_req_valid, 1'b0);
    chk1("rst_ifu_resp", ifu_resp_valid, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
    tick;
    rst = 1'b0;
    tick;

    // IFU-only fetch
    ifu_req_valid = 1'b1; ifu_raddr = 32'h8000_0000; mem_req_ready = 1'b1;
    #1;
    chk1("f_ifu_ready", ifu_req_ready, 1'b1);
    chk1("f_lsu_ready", lsu_req_ready, 1'b0);
    chk1("f_idle_memv", mem_req_valid, 1'b0);
    tick;
    ifu_req_valid = 1'b0; ifu_raddr = 32'hDEAD_BEEF;
    #1;
    chk1("f_req_memv", mem_req_valid, 1'b1);
    chk32("f_req_addr", mem_addr, 32'h8000_0000);
    chk1("f_req_wen", mem_wen, 1'b0);
    chk32("f_req_wmask", {24'h0, mem_wmask}, 32'h0);
    chk1("f_req_ifu_ready", ifu_req_ready, 1'b0);
    tick;
    mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0093;
    #1;
    chk1("f_wait_memv", mem_req_valid, 1'b0);
    chk1("f_resp_valid", ifu_resp_valid, 1'b1);
    chk32("f_resp_data", ifu_rdata, 32'h0010_0093);
    chk1("f_lsu_resp", lsu_resp_valid, 1'b0);
    chk32("f_lsu_rdata", lsu_rdata, 32'h0);
    tick;
    mem_resp_valid = 1'b0;
    #1;
    chk1("f_done_resp", ifu_resp_valid, 1'b0);
    chk32("f_done_rdata", ifu_rdata, 32'h0);
    chk1("f_done_memv", mem_req_valid, 1'b0);

    // stray response in IDLE is ignored
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk1("i_ifu_resp", ifu_resp_valid, 1'b0);
    chk1("i_lsu_resp", lsu_resp_valid, 1'b0);
    chk32("i_ifu_rdata", ifu_rdata, 32'h0);
    tick;
    mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1;
    #1;
    chk1("i_still_idle", ifu_req_ready, 1'b1);
    chk1("i_memv", mem_req_valid, 1'b0);
    ifu_req_valid = 1'b0;
    tick;

    // both held valid: LSU x4, IFU, LSU
    ifu_req_valid = 1'b1; ifu_raddr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_1000; lsu_wen = 1'b0;
    mem_req_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      automatic logic exp_lsu = (g != 4);
      mem_resp_valid = 1'b0;
      #1;
      chk1($sformatf("s%0d_lsu_ready", g), lsu_req_ready, exp_lsu);
      chk1($sformatf("s%0d_ifu_ready", g), ifu_req_ready, !exp_lsu);
      tick;
      chk32($sformatf("s%0d_addr", g), mem_addr, exp_lsu ? 32'h0000_1000 : 32'h8000_0004);
      tick;
      mem_resp_valid = 1'b1; mem_rdata = 32'h1000_0000 + g;
      #1;
      chk1($sformatf("s%0d_lsu_resp", g), lsu_resp_valid, exp_lsu);
      chk1($sformatf("s%0d_ifu_resp", g), ifu_resp_valid, !exp_lsu);
      chk32($sformatf("s%0d_rdata", g), exp_lsu ? lsu_rdata : ifu_rdata, 32'h1000_0000 + g);
      tick;
    end
    mem_resp_valid = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick;

    // LSU store held in REQ by a slow memory
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1002;
    lsu_wdata = 32'hABCD_0000; lsu_wmask = 8'h0C; mem_req_ready = 1'b0;
    #1;
    chk1("st_lsu_ready", lsu_req_ready, 1'b1);
    tick;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 8'h0; lsu_wen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mem_req_ready = (c == 3);
      mem_resp_valid = (c == 1);
      #1;
      chk1($sformatf("st%0d_memv", c), mem_req_valid, 1'b1);
      chk32($sformatf("st%0d_addr", c), mem_addr, 32'h8000_1002);
      chk32($sformatf("st%0d_wdata", c), mem_wdata, 32'hABCD_0000);
      chk32($sformatf("st%0d_wmask", c), {24'h0, mem_wmask}, 32'h0000_000C);
      chk1($sformatf("st%0d_wen", c), mem_wen, 1'b1);
      chk1($sformatf("st%0d_no_resp", c), lsu_resp_valid, 1'b0);
      tick;
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
    #1;
    chk1("st_wait_memv", mem_req_valid, 1'b0);
    chk1("st_ack", lsu_resp_valid, 1'b1);
    chk1("st_ifu_resp", ifu_resp_valid, 1'b0);
    tick;
    mem_resp_valid = 1'b0;
    #1;
    chk1("st_ack_pulse", lsu_resp_valid, 1'b0);

    // reset while waiting drops the transaction
    ifu_req_valid = 1'b1; ifu_raddr = 32'h8000_0010; mem_req_ready = 1'b1;
    tick;
    ifu_req_valid = 1'b0;
    tick;
    rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    chk1("r_in_rst_resp", ifu_resp_valid, 1'b0);
    tick;
    rst = 1'b0;
    #1;
    chk1("r_post_resp", ifu_resp_valid, 1'b0);
    chk1("r_post_lresp", lsu_resp_valid, 1'b0);
    chk1("r_post_memv", mem_req_valid, 1'b0);
    chk32("r_post_addr", mem_addr, 32'h0);
    tick;
    mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_raddr = 32'h8000_0020;
    #1;
    chk1("r_new_ready", ifu_req_ready, 1'b1);
    tick;
    ifu_req_valid = 1'b0;
    #1;
    chk32("r_new_addr", mem_addr, 32'h8000_0020);
    tick;
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0013;
    #1;
    chk1("r_new_resp", ifu_resp_valid, 1'b1);
    chk32("r_new_rdata", ifu_rdata, 32'h0000_0013);
    tick;
    mem_resp_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
